rc_uart: RTL and testbench
==========================

Name: rc_uart

Overview:
- UART receive front-end for a remote-controlled vehicle; runs from the 50 MHz board clock.
- Receives 8N1 serial bytes at 115200 baud on rx_in, decodes the drive commands 'w', 'a', 's', 'd' and drives four direction LEDs.
- Also exports a free-running baud-rate clock, clk_uart, for debug and for neighbouring logic.

Parameters:
- CLKS_PER_BIT, 434, system clocks per UART bit (50 MHz / 115200, rounded).
- HALF_BIT, 217, clocks from the detected start edge to the start-bit mid-sample (CLKS_PER_BIT/2).

Ports:
- clk_50  input  1  system clock, 50 MHz, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_in  input  1  serial data; idle high; LSB first; 1 start, 8 data, 1 stop, no parity.
- clk_uart  output  1  baud clock; toggles every HALF_BIT clocks (period CLKS_PER_BIT), free-running, not phase-locked to rx data.
- led  output  4  one-hot command display: led[0]=w (forward), led[1]=a (left), led[2]=s (back), led[3]=d (right).

Behaviour:
- Interface: one clock (clk_50). Reset rst_n is asynchronous, active-low; every flop clears immediately on rst_n=0.
- Reset values: led=4'b0000, clk_uart=0, FSM=IDLE, counters=0, shift register=0, synchroniser flops=1 (idle level).
- rx_in passes through a 2-flop synchroniser; all decisions use the synchronised value rx_s.
- Baud generator: counter 0..HALF_BIT-1. At terminal count it wraps to 0 and toggles clk_uart. It runs continuously out of reset.
- Receive FSM states:
  - IDLE: wait for rx_s=0, then go to START with bit counter cleared.
  - START: count HALF_BIT-1 clocks to reach the bit middle. If rx_s=0, go to DATA and clear the counter. If rx_s=1, treat it as a glitch and return to IDLE.
  - DATA: every CLKS_PER_BIT clocks, sample rx_s into the shift register, LSB first (shift right, new bit into bit 7). After the 8th sample, go to STOP.
  - STOP: after CLKS_PER_BIT clocks, sample rx_s.
    - rx_s=1: byte valid; pulse internal rx_done for 1 cycle; go to IDLE.
    - rx_s=0: framing error; discard the byte; wait in IDLE for rx_s=1 before accepting a new start edge.
- Command decode, registered on the cycle after rx_done:
  - 0x77 'w' gives led=0001.
  - 0x61 'a' gives led=0010.
  - 0x73 's' gives led=0100.
  - 0x64 'd' gives led=1000.
  - Any other valid byte gives led=0000 (stop).
  - Discarded bytes leave led unchanged.
- led holds its value between bytes; at most one led bit is ever high.
- Back-to-back frames: the next start bit may arrive one bit time after the stop-bit start. The FSM is back in IDLE by the stop-bit middle, so no frame is lost.
- Latency: led updates at most 3 clocks after the stop-bit mid-sample (2 synchroniser + 1 decode). That is about 9.5 bit times (~4125 clocks) after the start edge.
- rst_n asserted mid-frame: FSM returns to IDLE and led clears. A frame already in progress when reset releases is resynchronised only at the next falling edge seen from IDLE.
- Tolerance: sampling at bit middle tolerates ±4% baud mismatch.

Test Plan:
1. Reset check: hold rst_n=0 with rx_in=1, release, wait 1000 clocks -> led=0000; clk_uart toggles every 217 clocks (period 434).
2. Send 'w' (0x77) at 434 clk/bit -> led=0001 within 4130 clocks of the start edge; led stays 0001 while the line idles.
3. Send 'a', 's', 'd' back-to-back, stop bit plus one idle bit between frames -> led 0010, then 0100, then 1000, each in turn; no frame missed.
4. Send 0x41 ('A') after 'w' -> led=0000. Then send 'w' with stop bit forced 0 -> byte discarded, led stays 0000. Then send a good 'd' -> led=1000.
5. Pulse rx_in low for 100 clocks (glitch) -> FSM returns to IDLE, led unchanged. A following valid 's' -> led=0100.
6. Assert rst_n=0 in the middle of the data bits of 'a' -> led=0000 immediately, no spurious update. After release, a complete 'w' -> led=0001.

Source files
------------

// File: rtl/rc_uart.sv
// rc_uart: 8N1 UART receiver for the RC vehicle command link.
// A 2-flop synchroniser feeds a mid-bit sampling receive FSM. Valid bytes
// 'w', 'a', 's' and 'd' are decoded to a one-hot LED pattern, and any other
// valid byte clears the LEDs. A free-running baud clock is exported on
// clk_uart. It is not phase-locked to the received data.
module rc_uart #(
   parameter int CLKS_PER_BIT = 434,
   parameter int HALF_BIT     = 217
) (
   input  logic       clk_50,
   input  logic       rst_n,
   input  logic       rx_in,
   output logic       clk_uart,
   output logic [3:0] led
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CPB_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HB_LAST  = CW'(HALF_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   // synchroniser, idle level is 1
   logic          rx_m_q;
   logic          rx_s_q;

   // baud generator
   logic [CW-1:0] baud_cnt_q, baud_cnt_d;
   logic          clk_uart_q, clk_uart_d;

   // receive FSM
   state_t        state_q, state_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          rx_done_q, rx_done_d;
   // set after a bad stop bit: a new start edge is only accepted once the
   // line has returned high, so a stuck-low line cannot fake a frame
   logic          frame_err_q, frame_err_d;

   // command display
   logic [3:0]    led_q, led_d;

   // Baud generator: wraps every HALF_BIT clocks and toggles clk_uart.
   always_comb begin
      baud_cnt_d = baud_cnt_q + 1'b1;
      clk_uart_d = clk_uart_q;
      if (baud_cnt_q == HB_LAST) begin
         baud_cnt_d = '0;
         clk_uart_d = ~clk_uart_q;
      end
   end

   // Receive FSM next-state: half-bit wait to the start-bit middle, then
   // whole-bit steps through eight data bits and the stop bit.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      rx_done_d   = 1'b0;
      frame_err_d = frame_err_q;
      case (state_q)
         S_IDLE: begin
            bit_cnt_d = '0;
            bit_idx_d = '0;
            if (frame_err_q) begin
               if (rx_s_q) frame_err_d = 1'b0;
            end else if (!rx_s_q) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_cnt_q == HB_LAST) begin
               bit_cnt_d = '0;
               // a line already back high at mid start bit was a glitch
               state_d   = rx_s_q ? S_IDLE : S_DATA;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (bit_cnt_q == CPB_LAST) begin
               bit_cnt_d = '0;
               shift_d   = {rx_s_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == 3'd7) state_d = S_STOP;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (bit_cnt_q == CPB_LAST) begin
               bit_cnt_d = '0;
               state_d   = S_IDLE;
               if (rx_s_q) rx_done_d   = 1'b1;
               else        frame_err_d = 1'b1;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Command decode: update the LEDs only on a valid byte, otherwise hold.
   always_comb begin
      led_d = led_q;
      if (rx_done_q) begin
         case (shift_q)
            8'h77:   led_d = 4'b0001; // 'w' forward
            8'h61:   led_d = 4'b0010; // 'a' left
            8'h73:   led_d = 4'b0100; // 's' back
            8'h64:   led_d = 4'b1000; // 'd' right
            default: led_d = 4'b0000; // anything else stops the vehicle
         endcase
      end
   end

   // All state registers with asynchronous active-low clear.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         rx_m_q      <= 1'b1;
         rx_s_q      <= 1'b1;
         baud_cnt_q  <= '0;
         clk_uart_q  <= 1'b0;
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
         led_q       <= 4'b0000;
      end else begin
         rx_m_q      <= rx_in;
         rx_s_q      <= rx_m_q;
         baud_cnt_q  <= baud_cnt_d;
         clk_uart_q  <= clk_uart_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         rx_done_q   <= rx_done_d;
         frame_err_q <= frame_err_d;
         led_q       <= led_d;
      end
   end

   assign clk_uart = clk_uart_q;
   assign led      = led_q;

endmodule

// File: tb/tb_rc_uart.sv
// tb_rc_uart: self-checking bench for rc_uart. Frames are driven at 434
// clocks per bit. The expected LED value for each checked frame is pushed
// to a queue when the frame starts. It is popped and compared after the
// stop bit ends.
module tb_rc_uart;

   localparam int CPB = 434;

   logic       clk_50 = 1'b0;
   logic       rst_n  = 1'b0;
   logic       rx_in  = 1'b1;
   logic       clk_uart;
   logic [3:0] led;

   logic [3:0] exp_q[$];
   logic [3:0] exp_model = 4'b0000; // reference LED state after the last driven frame
   logic [3:0] exp_cur   = 4'b0000; // reference LED state the DUT should show now
   int         n_vec = 0;
   int         n_err = 0;

   // clock / reset
   always #10 clk_50 = ~clk_50;

   rc_uart dut (
      .clk_50   (clk_50),
      .rst_n    (rst_n),
      .rx_in    (rx_in),
      .clk_uart (clk_uart),
      .led      (led)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] decode(input logic [7:0] b);
      case (b)
         8'h77:   return 4'b0001;
         8'h61:   return 4'b0010;
         8'h73:   return 4'b0100;
         8'h64:   return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   // Drive one 8N1 frame. With do_chk set, the expected result is queued.
   // The LEDs must still hold the old value at clock 2000 of the frame.
   // They must show the new value by clock 4130 after the start edge.
   task automatic send_frame(input logic [7:0] d, input logic stop_b,
                             input logic do_chk, input string tag);
      logic [9:0] bits;
      int k;
      bits = {stop_b, d, 1'b0};
      if (do_chk) begin
         if (stop_b) exp_model = decode(d);
         exp_q.push_back(exp_model);
      end
      k = 0;
      for (int i = 0; i < 10; i++) begin
         rx_in = bits[i];
         repeat (CPB) begin
            @(posedge clk_50);
            k++;
            if (do_chk && (k == 2000 || k == 4130)) begin
               @(negedge clk_50);
               if (k == 2000) chk({tag, "_hold"}, {28'd0, led}, {28'd0, exp_cur});
               else           chk({tag, "_lat"},  {28'd0, led}, {28'd0, exp_q[0]});
            end
         end
      end
      rx_in = 1'b1;
   endtask

   task automatic check_frame(input string tag);
      logic [3:0] e;
      @(negedge clk_50);
      e = exp_q.pop_front();
      chk({tag, "_end"}, {28'd0, led}, {28'd0, e});
      exp_cur = e;
   endtask

   task automatic idle_bits(input int n);
      rx_in = 1'b1;
      repeat (n * CPB) @(posedge clk_50);
   endtask

   task automatic frame(input logic [7:0] d, input logic stop_b, input string tag);
      send_frame(d, stop_b, 1'b1, tag);
      check_frame(tag);
   endtask

   // Count clocks until clk_uart changes, bounded by 1000 clocks.
   task automatic wait_toggle(output int n);
      logic prev;
      prev = clk_uart;
      n = 0;
      while (n < 1000) begin
         @(negedge clk_50);
         n++;
         if (clk_uart !== prev) break;
      end
   endtask

   initial begin
      int n;

      // 1: reset state and baud clock
      repeat (5) @(negedge clk_50);
      chk("reset_led", {28'd0, led}, 32'd0);
      chk("reset_clk_uart", {31'd0, clk_uart}, 32'd0);
      rst_n = 1'b1;
      wait_toggle(n);
      chk("baud_first", n, 217);
      chk("baud_level", {31'd0, clk_uart}, 32'd1);
      wait_toggle(n);
      chk("baud_half_period", n, 217);
      chk("baud_level2", {31'd0, clk_uart}, 32'd0);
      wait_toggle(n);
      chk("baud_half_period2", n, 217);
      repeat (400) @(negedge clk_50);
      chk("idle_led", {28'd0, led}, 32'd0);

      // 2: single 'w', then LEDs hold while the line idles
      frame(8'h77, 1'b1, "w1");
      idle_bits(3);
      @(negedge clk_50);
      chk("w1_idle_hold", {28'd0, led}, {28'd0, exp_cur});

      // 3: back-to-back a, s, d with one idle bit after each stop bit
      frame(8'h61, 1'b1, "a1");
      idle_bits(1);
      frame(8'h73, 1'b1, "s1");
      idle_bits(1);
      frame(8'h64, 1'b1, "d1");
      idle_bits($urandom_range(1, 2));

      // 4: unknown byte, framing error, then a good byte
      frame(8'h77, 1'b1, "w2");
      idle_bits(1);
      frame(8'h41, 1'b1, "A1");
      idle_bits(1);
      frame(8'h77, 1'b0, "w_bad");
      idle_bits(1);
      frame(8'h64, 1'b1, "d2");
      idle_bits($urandom_range(1, 2));

      // 5: short low glitch is rejected, then a good 's'
      rx_in = 1'b0;
      repeat (100) @(posedge clk_50);
      rx_in = 1'b1;
      repeat (1000) @(posedge clk_50);
      @(negedge clk_50);
      chk("glitch_hold", {28'd0, led}, {28'd0, exp_cur});
      frame(8'h73, 1'b1, "s2");
      idle_bits(1);

      // 6: reset in the middle of the data bits of 'a'
      fork
         send_frame(8'h61, 1'b1, 1'b0, "a_rst");
         begin
            repeat (1500) @(posedge clk_50);
            @(negedge clk_50);
            rst_n = 1'b0;
            #1;
            chk("rst_led", {28'd0, led}, 32'd0);
            chk("rst_clk_uart", {31'd0, clk_uart}, 32'd0);
         end
      join
      idle_bits(1);
      @(negedge clk_50);
      chk("rst_no_update", {28'd0, led}, 32'd0);
      rst_n = 1'b1;
      exp_model = 4'b0000;
      exp_cur   = 4'b0000;
      idle_bits(2);
      frame(8'h77, 1'b1, "w3");
      idle_bits(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
